// File: rtl/i2c_rxff_gen_pkg.sv
// Shared constants and types for the parametrised I2C receive FIFO.
// Optional registered head-of-FIFO output is selected with I2C_RXFF_REGOUT_EN.
package i2c_rxff_gen_pkg;

  localparam int DW_DEF   = 8;
  localparam int AW_DEF   = 4;
  localparam int OVCW_DEF = 4;

  // Per-cycle action on the overflow flag / lost-byte counter.
  typedef enum logic [1:0] {
    OV_HOLD    = 2'd0,
    OV_SET     = 2'd1,
    OV_RESTART = 2'd2,
    OV_CLEAR   = 2'd3
  } ov_op_e;

endpackage

// File: rtl/i2c_rxff_gen_ff_ptr.sv
// Wrap-bit FIFO pointer: AW+1 bits, increment enable, synchronous clear with priority.
module i2c_ff_ptr
  import i2c_rxff_gen_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic        pclk,
  input  logic        prst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [AW:0] ptr
);

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n)
      ptr <= '0;
    else if (clr)
      ptr <= '0;
    else if (inc)
      ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/i2c_rxff_gen.sv
// Parametrised I2C receive FIFO with count, threshold, sticky overflow and lost-byte counter.
// Define I2C_RXFF_REGOUT_EN to register rxff_data instead of reading the memory combinationally.
module i2c_rxff_gen
  import i2c_rxff_gen_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int OVCW = OVCW_DEF
) (
  input  logic            pclk,
  input  logic            prst_n,
  input  logic            apb_crx,
  input  logic            i_rxff_wr,
  input  logic [DW-1:0]   rxff_din,
  input  logic            apb_rxff_rd,
  input  logic [AW:0]     apb_rxff_thr,
  input  logic            apb_ovclr,
  output logic [DW-1:0]   rxff_data,
  output logic            rxff_rxne,
  output logic            rxff_full,
  output logic [AW:0]     rxff_cnt,
  output logic            rxff_thr_hit,
  output logic            rxff_ov,
  output logic [OVCW-1:0] rxff_lost
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          crx_q;
  logic          crx_up;
  logic          empty;
  logic          full;
  logic          wr_ok;
  logic          rd_ok;
  ov_op_e        ov_op;

  assign empty  = (wptr == rptr);
  assign full   = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign crx_up = apb_crx & ~crx_q;
  assign wr_ok  = i_rxff_wr & ~full;
  assign rd_ok  = apb_rxff_rd & ~empty;

  assign rxff_rxne    = ~empty;
  assign rxff_full    = full;
  assign rxff_cnt     = wptr - rptr;
  assign rxff_thr_hit = (apb_rxff_thr != '0) && (rxff_cnt >= apb_rxff_thr);

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n)
      crx_q <= 1'b0;
    else
      crx_q <= apb_crx;
  end

  // A flush edge wins over any same-cycle write or read.
  i2c_ff_ptr #(.AW(AW)) u_wptr (
    .pclk   (pclk),
    .prst_n (prst_n),
    .clr    (crx_up),
    .inc    (wr_ok),
    .ptr    (wptr)
  );

  i2c_ff_ptr #(.AW(AW)) u_rptr (
    .pclk   (pclk),
    .prst_n (prst_n),
    .clr    (crx_up),
    .inc    (rd_ok),
    .ptr    (rptr)
  );

  always_ff @(posedge pclk) begin
    if (wr_ok && !crx_up)
      mem[wptr[AW-1:0]] <= rxff_din;
  end

  always_comb begin
    ov_op = OV_HOLD;
    if (crx_up)
      ov_op = OV_CLEAR;
    else if (i_rxff_wr && full)
      ov_op = apb_ovclr ? OV_RESTART : OV_SET;
    else if (apb_ovclr)
      ov_op = OV_CLEAR;
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      rxff_ov   <= 1'b0;
      rxff_lost <= '0;
    end else begin
      case (ov_op)
        OV_SET: begin
          rxff_ov <= 1'b1;
          if (rxff_lost != '1)
            rxff_lost <= rxff_lost + 1'b1;
        end
        OV_RESTART: begin
          rxff_ov   <= 1'b1;
          rxff_lost <= {{(OVCW-1){1'b0}}, 1'b1};
        end
        OV_CLEAR: begin
          rxff_ov   <= 1'b0;
          rxff_lost <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef I2C_RXFF_REGOUT_EN
  logic [AW:0]   rptr_next;
  logic [DW-1:0] data_reg;

  assign rptr_next = rptr + {{AW{1'b0}}, rd_ok};

  // The slot about to become head may be written on this same edge, so bypass rxff_din.
  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n)
      data_reg <= '0;
    else if (crx_up)
      data_reg <= '0;
    else if (rd_ok || (wr_ok && empty))
      data_reg <= (wr_ok && (wptr == rptr_next)) ? rxff_din : mem[rptr_next[AW-1:0]];
  end

  assign rxff_data = data_reg;
`else
  assign rxff_data = mem[rptr[AW-1:0]];
`endif

endmodule

// File: tb/tb_i2c_rxff_gen.sv
// Scoreboard bench for i2c_rxff_gen: queue-based reference model, directed phases then random traffic.
module tb_i2c_rxff_gen;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int OVCW  = 4;
  localparam int DEPTH = 16;

  logic            pclk = 1'b0;
  logic            prst_n = 1'b0;
  logic            apb_crx = 1'b0;
  logic            i_rxff_wr = 1'b0;
  logic [DW-1:0]   rxff_din = '0;
  logic            apb_rxff_rd = 1'b0;
  logic [AW:0]     apb_rxff_thr = '0;
  logic            apb_ovclr = 1'b0;
  logic [DW-1:0]   rxff_data;
  logic            rxff_rxne;
  logic            rxff_full;
  logic [AW:0]     rxff_cnt;
  logic            rxff_thr_hit;
  logic            rxff_ov;
  logic [OVCW-1:0] rxff_lost;

  i2c_rxff_gen #(.DW(DW), .AW(AW), .OVCW(OVCW)) dut (
    .pclk         (pclk),
    .prst_n       (prst_n),
    .apb_crx      (apb_crx),
    .i_rxff_wr    (i_rxff_wr),
    .rxff_din     (rxff_din),
    .apb_rxff_rd  (apb_rxff_rd),
    .apb_rxff_thr (apb_rxff_thr),
    .apb_ovclr    (apb_ovclr),
    .rxff_data    (rxff_data),
    .rxff_rxne    (rxff_rxne),
    .rxff_full    (rxff_full),
    .rxff_cnt     (rxff_cnt),
    .rxff_thr_hit (rxff_thr_hit),
    .rxff_ov      (rxff_ov),
    .rxff_lost    (rxff_lost)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] mq[$];
  logic [DW-1:0] exp_q[$];
  int            m_ov = 0;
  int            m_lost = 0;
  bit            m_crx_q = 1'b0;
  bit            skip_mon = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status();
    int sz;
    int thr;
    sz  = mq.size();
    thr = int'(apb_rxff_thr);
    chk("cnt",  32'(rxff_cnt), 32'(sz));
    chk("rxne", 32'(rxff_rxne), 32'(sz != 0));
    chk("full", 32'(rxff_full), 32'(sz == DEPTH));
    chk("ov",   32'(rxff_ov), 32'(m_ov));
    chk("lost", 32'(rxff_lost), 32'(m_lost));
    chk("thr_hit", 32'(rxff_thr_hit), 32'((thr != 0) && (sz >= thr)));
    if (sz != 0)
      chk("head", 32'(rxff_data), 32'(mq[0]));
    $display("cyc t=%0t wr=%0b rd=%0b crx=%0b clr=%0b cnt=%0d ov=%0b lost=%0d", $time,
             i_rxff_wr, apb_rxff_rd, apb_crx, apb_ovclr, rxff_cnt, rxff_ov, rxff_lost);
  endtask

  // Called at a falling edge; drives one cycle of inputs, updates the model, checks after the next edge.
  task automatic cycle(input bit wr, input logic [DW-1:0] d, input bit rd, input bit crx, input bit clr);
    bit up;
    bit full_pre;
    i_rxff_wr   = wr;
    rxff_din    = d;
    apb_rxff_rd = rd;
    apb_crx     = crx;
    apb_ovclr   = clr;
    up       = crx && !m_crx_q;
    full_pre = (mq.size() == DEPTH);
    skip_mon = up;
    if (up) begin
      mq.delete();
      m_ov   = 0;
      m_lost = 0;
    end else begin
      if (rd && mq.size() > 0)
        exp_q.push_back(mq.pop_front());
      if (wr && !full_pre)
        mq.push_back(d);
      if (wr && full_pre) begin
        m_ov   = 1;
        m_lost = clr ? 1 : ((m_lost == (1 << OVCW) - 1) ? m_lost : m_lost + 1);
      end else if (clr) begin
        m_ov   = 0;
        m_lost = 0;
      end
    end
    m_crx_q = crx;
    @(posedge pclk);
    @(negedge pclk);
    check_status();
  endtask

  task automatic wr1(input logic [DW-1:0] d);
    cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rd1();
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic drain();
    while (mq.size() > 0) rd1();
  endtask

  // Scoreboard monitor: every accepted read must deliver the next expected byte.
  always @(negedge pclk) begin
    logic [DW-1:0] e;
    #2;
    if (prst_n && apb_rxff_rd && rxff_rxne && !skip_mon) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_unexpected: got 0x%0h expected no pop at %0t", rxff_data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("pop_data", 32'(rxff_data), 32'(e));
      end
    end
  end

  initial begin
    repeat (2) @(negedge pclk);
    #1;
    chk("rst_rxne", 32'(rxff_rxne), 32'd0);
    chk("rst_cnt",  32'(rxff_cnt), 32'd0);
    chk("rst_ov",   32'(rxff_ov), 32'd0);
    chk("rst_lost", 32'(rxff_lost), 32'd0);
    @(negedge pclk);
    prst_n = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Basic write / read order
    wr1(8'h11); wr1(8'h22); wr1(8'h33);
    rd1(); rd1(); rd1();

    // Fill, overflow by three, clear
    for (int i = 0; i < DEPTH; i++) wr1(8'(i));
    for (int i = 0; i < 3; i++) wr1(8'hA0 + 8'(i));
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    drain();

    // Steady state at 15 with simultaneous write+read across pointer wraps
    for (int i = 0; i < DEPTH - 1; i++) wr1(8'h40 + 8'(i));
    for (int i = 0; i < 40; i++) cycle(1'b1, 8'h80 + 8'(i), 1'b1, 1'b0, 1'b0);
    drain();

    // Threshold
    apb_rxff_thr = 5'd8;
    for (int i = 0; i < 8; i++) wr1(8'hC0 + 8'(i));
    rd1();
    apb_rxff_thr = 5'd0;
    wr1(8'hD0);
    drain();

    // Flush: edge-detected, held level flushes once
    for (int i = 0; i < 5; i++) wr1(8'h50 + 8'(i));
    for (int i = 0; i < DEPTH; i++) wr1(8'h60);
    cycle(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    wr1(8'h99);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    drain();

    // Overflow coincident with clear, then saturation of the lost counter
    for (int i = 0; i < DEPTH; i++) wr1(8'hE0 + 8'(i));
    wr1(8'hF0);
    cycle(1'b1, 8'hF1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) wr1(8'hF2);

    // Asynchronous reset mid-burst
    apb_rxff_rd = 1'b0;
    #3;
    prst_n = 1'b0;
    #1;
    chk("arst_rxne", 32'(rxff_rxne), 32'd0);
    chk("arst_full", 32'(rxff_full), 32'd0);
    chk("arst_cnt",  32'(rxff_cnt), 32'd0);
    chk("arst_thr",  32'(rxff_thr_hit), 32'd0);
    chk("arst_ov",   32'(rxff_ov), 32'd0);
    chk("arst_lost", 32'(rxff_lost), 32'd0);
    mq.delete();
    m_ov = 0;
    m_lost = 0;
    m_crx_q = 1'b0;
    i_rxff_wr = 1'b0;
    apb_crx = 1'b0;
    apb_ovclr = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    prst_n = 1'b1;
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0)
        apb_rxff_thr = 5'($urandom_range(0, DEPTH));
      cycle($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 45,
            $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3);
    end
    drain();
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
